// File: rtl/rs255_251_enc.sv
// rs255_251_enc -- byte-serial systematic Reed-Solomon RS(255,251) encoder,
// GF(2^8) with field polynomial 0x11D, generator roots alpha^0..alpha^3.
//
// Data symbols are forwarded unchanged. After the last data symbol, four
// parity symbols are appended (highest-order remainder coefficient first).
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_data/in_sop/in_eop input symbol and codeword framing
//   out_valid/out_ready   output handshake
//   out_data              data or parity symbol
//   out_sop/out_eop       first symbol / last parity symbol of a codeword
//   out_par               out_data carries a parity symbol
//   sop_err               one-cycle pulse: symbol without sop in IDLE, or sop mid-codeword
//   len_err               one-cycle pulse: codeword force-closed at K data symbols
module rs255_251_enc #(
    parameter int K    = 251,
    parameter int NPAR = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_sop,
    input  logic       in_eop,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_sop,
    output logic       out_eop,
    output logic       out_par,
    output logic       sop_err,
    output logic       len_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAR  = 2'd2
    } state_t;

    localparam logic [7:0] K_CNT    = 8'(K);
    localparam logic [1:0] LAST_PAR = 2'(NPAR - 1);

    // g(x) = x^4 + G3 x^3 + G2 x^2 + G1 x + G0
    localparam logic [7:0] G3 = 8'h0F;
    localparam logic [7:0] G2 = 8'h36;
    localparam logic [7:0] G1 = 8'h78;
    localparam logic [7:0] G0 = 8'h40;

    // GF(2^8) multiply modulo 0x11D (shift-and-add).
    function automatic logic [7:0] gf256mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end else begin
                p = p;
            end
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    state_t     state_r, state_s;
    logic [7:0] r3_r, r2_r, r1_r, r0_r;
    logic [7:0] r3_s, r2_s, r1_s, r0_s;
    logic [7:0] cnt_r, cnt_s;
    logic [1:0] pcnt_r, pcnt_s;
    logic       out_valid_r, out_valid_s;
    logic [7:0] out_data_r, out_data_s;
    logic       out_sop_r, out_sop_s;
    logic       out_eop_r, out_eop_s;
    logic       out_par_r, out_par_s;
    logic       sop_err_r, sop_err_s;
    logic       len_err_r, len_err_s;

    logic       load_s;
    logic       accept_s;
    logic [7:0] cnt_inc_s;
    logic [7:0] fb_s;
    logic [7:0] b2_s, b1_s, b0_s;
    logic [7:0] u3_s, u2_s, u1_s, u0_s;

    // Output register may load when empty or being drained this cycle.
    assign load_s    = !out_valid_r || out_ready;
    assign in_ready  = (state_r != S_PAR) && load_s;
    assign accept_s  = in_valid && in_ready;
    assign cnt_inc_s = cnt_r + 8'd1;

    // An sop symbol restarts the division from an all-zero remainder, which
    // also discards the state of an abandoned codeword.
    assign fb_s = in_data ^ (in_sop ? 8'h00 : r3_r);
    assign b2_s = in_sop ? 8'h00 : r2_r;
    assign b1_s = in_sop ? 8'h00 : r1_r;
    assign b0_s = in_sop ? 8'h00 : r0_r;
    assign u3_s = b2_s ^ gf256mul(fb_s, G3);
    assign u2_s = b1_s ^ gf256mul(fb_s, G2);
    assign u1_s = b0_s ^ gf256mul(fb_s, G1);
    assign u0_s = gf256mul(fb_s, G0);

    // Next-state, LFSR, counters and output-register load.
    always_comb begin
        state_s     = state_r;
        r3_s        = r3_r;
        r2_s        = r2_r;
        r1_s        = r1_r;
        r0_s        = r0_r;
        cnt_s       = cnt_r;
        pcnt_s      = pcnt_r;
        out_valid_s = load_s ? 1'b0 : out_valid_r;
        out_data_s  = out_data_r;
        out_sop_s   = load_s ? 1'b0 : out_sop_r;
        out_eop_s   = load_s ? 1'b0 : out_eop_r;
        out_par_s   = load_s ? 1'b0 : out_par_r;
        sop_err_s   = 1'b0;
        len_err_s   = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (accept_s && in_sop) begin
                    out_valid_s = 1'b1;
                    out_data_s  = in_data;
                    out_sop_s   = 1'b1;
                    r3_s        = u3_s;
                    r2_s        = u2_s;
                    r1_s        = u1_s;
                    r0_s        = u0_s;
                    cnt_s       = 8'd1;
                    state_s     = in_eop ? S_PAR : S_DATA;
                end else if (accept_s) begin
                    // Symbol outside a codeword: dropped.
                    sop_err_s = 1'b1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_DATA: begin
                if (accept_s) begin
                    out_valid_s = 1'b1;
                    out_data_s  = in_data;
                    out_sop_s   = in_sop;
                    r3_s        = u3_s;
                    r2_s        = u2_s;
                    r1_s        = u1_s;
                    r0_s        = u0_s;
                    if (in_sop) begin
                        sop_err_s = 1'b1;
                        cnt_s     = 8'd1;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                    if (in_eop) begin
                        state_s = S_PAR;
                    end else if (!in_sop && (cnt_inc_s == K_CNT)) begin
                        state_s   = S_PAR;
                        len_err_s = 1'b1;
                    end else begin
                        state_s = S_DATA;
                    end
                end else begin
                    state_s = S_DATA;
                end
            end
            S_PAR: begin
                if (load_s) begin
                    out_valid_s = 1'b1;
                    out_data_s  = r3_r;
                    out_par_s   = 1'b1;
                    r3_s        = r2_r;
                    r2_s        = r1_r;
                    r1_s        = r0_r;
                    r0_s        = 8'h00;
                    if (pcnt_r == LAST_PAR) begin
                        out_eop_s = 1'b1;
                        pcnt_s    = 2'd0;
                        state_s   = S_IDLE;
                    end else begin
                        pcnt_s = pcnt_r + 2'd1;
                    end
                end else begin
                    state_s = S_PAR;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, LFSR, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            r3_r        <= 8'h00;
            r2_r        <= 8'h00;
            r1_r        <= 8'h00;
            r0_r        <= 8'h00;
            cnt_r       <= 8'd0;
            pcnt_r      <= 2'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
            out_sop_r   <= 1'b0;
            out_eop_r   <= 1'b0;
            out_par_r   <= 1'b0;
            sop_err_r   <= 1'b0;
            len_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            r3_r        <= r3_s;
            r2_r        <= r2_s;
            r1_r        <= r1_s;
            r0_r        <= r0_s;
            cnt_r       <= cnt_s;
            pcnt_r      <= pcnt_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            out_sop_r   <= out_sop_s;
            out_eop_r   <= out_eop_s;
            out_par_r   <= out_par_s;
            sop_err_r   <= sop_err_s;
            len_err_r   <= len_err_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sop   = out_sop_r;
    assign out_eop   = out_eop_r;
    assign out_par   = out_par_r;
    assign sop_err   = sop_err_r;
    assign len_err   = len_err_r;

endmodule
